bch_pipe2_top: RTL and testbench
================================

BCH_PIPE2_TOP -- requirements
Module: bch_pipe2_top

Interface
REQ-001 The block SHALL have no parameters; the code is fixed as BCH(15,7), t=2, over GF(2^4) with primitive polynomial x^4+x+1.
REQ-002 Port `clk`, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 Port `rst`, input, 1 bit: synchronous, active-high reset.
REQ-004 Port `codeword`, input, 15 bits: received word, sampled every cycle; bit i is the coefficient of x^i.
REQ-005 Port `corrected_codeword`, output, 15 bits: decoded word, registered.
REQ-006 Port `error_flag`, output, 1 bit: registered; high when the received word had nonzero syndrome.

Function
REQ-007 Codewords SHALL be systematic: message in bits [14:8], parity in bits [7:0].
- Generator polynomial g(x)=x^8+x^7+x^6+x^4+1.
REQ-008 Stage 1 SHALL compute the syndromes combinationally from `codeword`: S1=r(α) and S3=r(α^3).
- On each clock edge, S1, S3 and the raw word SHALL be registered.
REQ-009 Stage 2 SHALL compute the inversion-less Berlekamp-Massey locator from the registered syndromes.
- Λ0=S1, Λ1=S1^2, Λ2=S3+S1^3, all GF(16).
REQ-010 Locator cases:
- S1=0 and S3=0: no error.
- S1≠0 and S3=S1^3: single error; Λ2=0, degree 1.
- S1≠0 and S3≠S1^3: two errors, degree 2.
- S1=0 and S3≠0: uncorrectable.
REQ-011 Chien search SHALL evaluate Λ(α^-i) for i=0..14 in parallel, in the same cycle as REQ-009.
- Bit i is in error iff the result is 0.
REQ-012 The corrected word SHALL be the stage-1 registered word XOR the Chien error vector.
- It SHALL be registered into `corrected_codeword` at the end of stage 2.
REQ-013 Latency SHALL be exactly 2 clock cycles from `codeword` sampling to `corrected_codeword`/`error_flag` valid.
- Throughput SHALL be one word per cycle with no stalls and no handshake.
REQ-014 `error_flag` SHALL equal (S1≠0 or S3≠0) of the same word and be aligned with its `corrected_codeword`.
REQ-015 When syndromes are zero, the output SHALL equal the input word unchanged.
REQ-016 All GF multiplications SHALL be combinational, reduced modulo x^4+x+1; addition is XOR.

Reset
REQ-017 While `rst`=1 at a clock edge, all pipeline registers SHALL clear to 0: `corrected_codeword`=15'h0000, `error_flag`=0.
REQ-018 Reset asserted mid-stream SHALL discard in-flight words.
- The first valid output after deassertion SHALL be the word sampled on the first edge with `rst`=0, appearing 2 cycles later.

Configuration
REQ-019 Macro `BCH_FAIL_DETECT_EN` SHALL control decoder-failure handling.
- Defined: if the Chien root count ≠ locator degree, or the REQ-010 case is uncorrectable, `corrected_codeword` SHALL equal the received word unmodified; `error_flag` stays 1.
- Undefined: the Chien error vector SHALL always be applied as found.

Verification
REQ-020 Zero/clean word: `codeword`=15'h01D1 (message 1) -> after 2 cycles `corrected_codeword`=15'h01D1, `error_flag`=0; all-zero word -> 0, flag 0.
REQ-021 Single errors: 15'h01D1 XOR (1<<i) for i=0..14 -> `corrected_codeword`=15'h01D1, `error_flag`=1 for every i.
REQ-022 Double errors: all 105 two-bit patterns applied to 15'h01D1 back-to-back, one per cycle -> each output 15'h01D1, flag 1, each exactly 2 cycles after its input.
- Example: 15'h41D9 (bits 14 and 3 flipped) -> 15'h01D1.
REQ-023 Uncorrectable, macro defined: word with S1=0 and S3≠0 -> output equals input, flag 1.
REQ-024 Reset: reset asserted during a 2-error stream -> next two outputs 15'h0000/flag 0; stream restarts with correct 2-cycle alignment.

Source files
------------

// File: rtl/bch_pipe2_top.sv
// -----------------------------------------------------------------------------
// bch_pipe2_top
//
// Purpose:
//   Two-stage pipelined BCH(15,7) decoder, t=2, over GF(2^4) with primitive
//   polynomial x^4+x+1. Codewords are systematic: message in [14:8], parity
//   in [7:0], generator g(x)=x^8+x^7+x^6+x^4+1. One word accepted per cycle,
//   no handshake, fixed latency of two clock edges.
//
//   Stage 1: syndromes S1=r(a), S3=r(a^3) computed from the input word and
//            registered together with the raw word.
//   Stage 2: inversion-less locator
//              L(x) = S1 + S1^2 x + (S3 + S1^3) x^2
//            followed by a parallel Chien search over all 15 positions.
//            The corrected word and error flag are registered.
//
// Ports:
//   clk                 in   single clock, rising edge
//   rst                 in   synchronous active-high reset, clears pipeline
//   codeword[14:0]      in   received word, bit i = coefficient of x^i
//   corrected_codeword  out  decoded word (registered)
//   error_flag          out  1 when the word had a nonzero syndrome
//
// Configuration:
//   BCH_FAIL_DETECT_EN  when defined, a decoder failure (uncorrectable
//                       syndrome pattern, or Chien root count different from
//                       the locator degree) passes the received word through
//                       unmodified. When undefined, the Chien error vector is
//                       always applied as found.
// -----------------------------------------------------------------------------
module bch_pipe2_top (
  input  logic        clk,
  input  logic        rst,
  input  logic [14:0] codeword,
  output logic [14:0] corrected_codeword,
  output logic        error_flag
);

  // ---------------------------------------------------------------------------
  // GF(16) arithmetic, polynomial basis, reduction by x^4+x+1
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] gf_xtime(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = 4'h0;
    sh  = a;
    for (int k = 0; k < 4; k++) begin
      if (b[k]) acc = acc ^ sh;
      sh = gf_xtime(sh);
    end
    return acc;
  endfunction

  // a^e for e in 0..14; e=15 folds back to a^0
  function automatic logic [3:0] alpha_pow(input logic [3:0] e);
    logic [3:0] v;
    case (e)
      4'd0:    v = 4'h1;
      4'd1:    v = 4'h2;
      4'd2:    v = 4'h4;
      4'd3:    v = 4'h8;
      4'd4:    v = 4'h3;
      4'd5:    v = 4'h6;
      4'd6:    v = 4'hC;
      4'd7:    v = 4'hB;
      4'd8:    v = 4'h5;
      4'd9:    v = 4'hA;
      4'd10:   v = 4'h7;
      4'd11:   v = 4'hE;
      4'd12:   v = 4'hF;
      4'd13:   v = 4'hD;
      4'd14:   v = 4'h9;
      default: v = 4'h1;
    endcase
    return v;
  endfunction

  // S1 = r(a): sum of a^i over set bits
  function automatic logic [3:0] syndrome1(input logic [14:0] r);
    logic [3:0] acc;
    acc = 4'h0;
    for (int i = 0; i < 15; i++) begin
      if (r[i]) acc = acc ^ alpha_pow(4'(i));
    end
    return acc;
  endfunction

  // S3 = r(a^3): sum of a^(3i mod 15) over set bits
  function automatic logic [3:0] syndrome3(input logic [14:0] r);
    logic [3:0] acc;
    acc = 4'h0;
    for (int i = 0; i < 15; i++) begin
      if (r[i]) acc = acc ^ alpha_pow(4'((3 * i) % 15));
    end
    return acc;
  endfunction

  // Parallel Chien search: bit i set when L(a^-i) == 0
  function automatic logic [14:0] chien_roots(input logic [3:0] l0,
                                              input logic [3:0] l1,
                                              input logic [3:0] l2);
    logic [14:0] roots;
    logic [3:0]  x;
    logic [3:0]  val;
    roots = 15'h0000;
    for (int i = 0; i < 15; i++) begin
      x        = alpha_pow(4'((15 - i) % 15));
      val      = l0 ^ gf_mul(l1, x) ^ gf_mul(l2, gf_mul(x, x));
      roots[i] = (val == 4'h0);
    end
    return roots;
  endfunction

`ifdef BCH_FAIL_DETECT_EN
  function automatic logic [3:0] popcount15(input logic [14:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 15; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Stage 1: syndromes and raw word
  // ---------------------------------------------------------------------------
  logic [3:0]  s1_d;
  logic [3:0]  s3_d;
  logic [3:0]  s1_q;
  logic [3:0]  s3_q;
  logic [14:0] word_q;

  always_comb begin
    s1_d = syndrome1(codeword);
    s3_d = syndrome3(codeword);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 4'h0;
      s3_q   <= 4'h0;
      word_q <= 15'h0000;
    end else begin
      s1_q   <= s1_d;
      s3_q   <= s3_d;
      word_q <= codeword;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: locator, Chien search, correction
  // ---------------------------------------------------------------------------
  logic [3:0]  s1_sq;
  logic [3:0]  s1_cu;
  logic [3:0]  lam0;
  logic [3:0]  lam1;
  logic [3:0]  lam2;
  logic [14:0] roots;
  logic [14:0] err_vec;
  logic [14:0] applied_vec;
  logic        syn_nonzero;

  always_comb begin
    s1_sq       = gf_mul(s1_q, s1_q);
    s1_cu       = gf_mul(s1_sq, s1_q);
    lam0        = s1_q;
    lam1        = s1_sq;
    lam2        = s3_q ^ s1_cu;
    roots       = chien_roots(lam0, lam1, lam2);
    syn_nonzero = (s1_q != 4'h0) || (s3_q != 4'h0);
    // With S1=0 the locator degenerates (all-zero or S3*x^2), so no position
    // can be a genuine error location; mask the search result.
    err_vec     = (s1_q != 4'h0) ? roots : 15'h0000;
  end

`ifdef BCH_FAIL_DETECT_EN
  logic [3:0] root_count;
  logic [3:0] lam_degree;
  logic       uncorrectable;
  logic       decode_fail;

  always_comb begin
    root_count    = popcount15(err_vec);
    lam_degree    = (lam2 != 4'h0) ? 4'd2 : 4'd1;
    uncorrectable = (s1_q == 4'h0) && (s3_q != 4'h0);
    decode_fail   = uncorrectable ||
                    ((s1_q != 4'h0) && (root_count != lam_degree));
    applied_vec   = decode_fail ? 15'h0000 : err_vec;
  end
`else
  always_comb begin
    applied_vec = err_vec;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      corrected_codeword <= 15'h0000;
      error_flag         <= 1'b0;
    end else begin
      corrected_codeword <= word_q ^ applied_vec;
      error_flag         <= syn_nonzero;
    end
  end

endmodule

// File: tb/tb_bch_pipe2_top.sv
module tb_bch_pipe2_top;

  logic        clk;
  logic        rst;
  logic [14:0] codeword;
  logic [14:0] corrected_codeword;
  logic        error_flag;

  int n_cmp = 0;
  int n_bad = 0;

  // {flag, word}; the head entry always models what stage 1 currently holds
  logic [15:0] exp_q[$];

  localparam logic [14:0] CW1 = 15'h01D1;

  bch_pipe2_top dut (
    .clk                (clk),
    .rst                (rst),
    .codeword           (codeword),
    .corrected_codeword (corrected_codeword),
    .error_flag         (error_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Systematic encoder: parity = (m(x) * x^8) mod g(x)
  function automatic logic [14:0] encode(input logic [6:0] m);
    logic [14:0] r;
    logic [14:0] g;
    g = 15'h01D1;
    r = {m, 8'h00};
    for (int i = 14; i >= 8; i--) begin
      if (r[i]) r = r ^ (g << (i - 8));
    end
    return {m, r[7:0]};
  endfunction

  // Drive one word, record its expectation, advance one edge, settle.
  task automatic drive_word(input logic [14:0] w, input logic [14:0] ew, input logic ef);
    codeword = w;
    exp_q.push_back({ef, ew});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    codeword = 15'h7FFF;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (corrected_codeword !== 15'h0000 || error_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got %h/%b want 0000/0", corrected_codeword, error_flag);
    end
    exp_q.delete();
    exp_q.push_back(16'h0000);
    rst = 1'b0;
  endtask

  task automatic test_clean();
    logic [14:0] words[$];
    logic [15:0] e;
    words = '{CW1, 15'h0000, encode(7'h7F), encode(7'h55), encode(7'h2A), CW1};
    foreach (words[k]) begin
      drive_word(words[k], words[k], 1'b0);
      n_cmp++;
      if (exp_q.size() < 2) begin
        n_bad++;
        $display("FAIL clean_underflow: queue size %0d want 2", exp_q.size());
      end else begin
        e = exp_q.pop_front();
        if (corrected_codeword !== e[14:0] || error_flag !== e[15]) begin
          n_bad++;
          $display("FAIL clean[%0d]: got %h/%b want %h/%b", k, corrected_codeword,
                   error_flag, e[14:0], e[15]);
        end
      end
    end
  endtask

  task automatic test_single();
    logic [15:0] e;
    for (int i = 0; i < 15; i++) begin
      drive_word(CW1 ^ (15'h0001 << i), CW1, 1'b1);
      n_cmp++;
      if (exp_q.size() < 2) begin
        n_bad++;
        $display("FAIL single_underflow: queue size %0d want 2", exp_q.size());
      end else begin
        e = exp_q.pop_front();
        if (corrected_codeword !== e[14:0] || error_flag !== e[15]) begin
          n_bad++;
          $display("FAIL single(in=%h): got %h/%b want %h/%b", CW1 ^ (15'h0001 << i),
                   corrected_codeword, error_flag, e[14:0], e[15]);
        end
      end
    end
  endtask

  task automatic test_double();
    logic [15:0] e;
    logic [14:0] w;
    for (int i = 0; i < 15; i++) begin
      for (int j = i + 1; j < 15; j++) begin
        w = CW1 ^ (15'h0001 << i) ^ (15'h0001 << j);
        drive_word(w, CW1, 1'b1);
        n_cmp++;
        if (exp_q.size() < 2) begin
          n_bad++;
          $display("FAIL double_underflow: queue size %0d want 2", exp_q.size());
        end else begin
          e = exp_q.pop_front();
          if (corrected_codeword !== e[14:0] || error_flag !== e[15]) begin
            n_bad++;
            $display("FAIL double(bits %0d,%0d): got %h/%b want %h/%b", i, j,
                     corrected_codeword, error_flag, e[14:0], e[15]);
          end
        end
      end
    end
  endtask

  // x^4+x+1 has a as a root, so S1=0 while S3=a^12+a^3+1 != 0.
  task automatic test_uncorrectable();
    logic [14:0] words[$];
    logic [15:0] e;
    words = '{15'h0013, CW1 ^ 15'h0013, 15'h0013 << 3};
    foreach (words[k]) begin
      drive_word(words[k], words[k], 1'b1);
      n_cmp++;
      if (exp_q.size() < 2) begin
        n_bad++;
        $display("FAIL uncorr_underflow: queue size %0d want 2", exp_q.size());
      end else begin
        e = exp_q.pop_front();
        if (corrected_codeword !== e[14:0] || error_flag !== e[15]) begin
          n_bad++;
          $display("FAIL uncorrectable[%0d]: got %h/%b want %h/%b", k,
                   corrected_codeword, error_flag, e[14:0], e[15]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] e;
    logic [14:0] cw;
    logic [14:0] ev;
    int          nerr;
    int          p1;
    int          p2;
    for (int n = 0; n < 60; n++) begin
      cw   = encode(7'($urandom_range(127)));
      nerr = $urandom_range(2);
      p1   = $urandom_range(14);
      p2   = (p1 + 1 + $urandom_range(13)) % 15;
      ev   = 15'h0000;
      if (nerr >= 1) ev[p1] = 1'b1;
      if (nerr == 2) ev[p2] = 1'b1;
      drive_word(cw ^ ev, cw, (nerr != 0));
      n_cmp++;
      if (exp_q.size() < 2) begin
        n_bad++;
        $display("FAIL random_underflow: queue size %0d want 2", exp_q.size());
      end else begin
        e = exp_q.pop_front();
        if (corrected_codeword !== e[14:0] || error_flag !== e[15]) begin
          n_bad++;
          $display("FAIL random[%0d]: got %h/%b want %h/%b", n, corrected_codeword,
                   error_flag, e[14:0], e[15]);
        end
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic [15:0] e;
    logic [14:0] w;
    for (int n = 0; n < 12; n++) begin
      if (n == 5) begin
        // Reset lands while two words are in flight; both are discarded.
        rst      = 1'b1;
        codeword = CW1 ^ 15'h4008;
        @(posedge clk);
        #1;
        n_cmp++;
        if (corrected_codeword !== 15'h0000 || error_flag !== 1'b0) begin
          n_bad++;
          $display("FAIL midreset_hold: got %h/%b want 0000/0", corrected_codeword, error_flag);
        end
        exp_q.delete();
        exp_q.push_back(16'h0000);
        rst = 1'b0;
      end
      w = CW1 ^ (15'h0001 << (n % 15)) ^ (15'h0001 << ((n + 4) % 15));
      drive_word(w, CW1, 1'b1);
      n_cmp++;
      if (exp_q.size() < 2) begin
        n_bad++;
        $display("FAIL midreset_underflow: queue size %0d want 2", exp_q.size());
      end else begin
        e = exp_q.pop_front();
        if (corrected_codeword !== e[14:0] || error_flag !== e[15]) begin
          n_bad++;
          $display("FAIL midreset[%0d]: got %h/%b want %h/%b", n, corrected_codeword,
                   error_flag, e[14:0], e[15]);
        end
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    codeword = 15'h0000;
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_uncorrectable();
    test_random();
    test_midstream_reset();
    test_clean();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
